// File: rtl/l2_noc_iso_ctrl.sv
// l2_noc_iso_ctrl: NoC isolation controller for the L2 partition.
// Drives the asynchronous NoC idle-request handshake and the NoC clock enable
// in response to a level isolation request. It synchronises the NoC-side
// ack/val, and gates the clock only after idle is confirmed. It also reports
// a refusal or a REQ timeout as one-cycle pulses.
//
// Ports:
//   i_clk, i_rst              clock (rising edge), asynchronous active-high reset
//   i_isolate_req             level request: 1 = isolate, 0 = run
//   i_timeout_cycles          REQ timeout in cycles (0 = disabled)
//   o_isolate_ack             high while ISOLATED
//   o_refused, o_timeout      one-cycle status pulses
//   o_state                   current FSM state (debug)
//   o_noc_async_idle_req      idle request to the NoC
//   i_noc_async_idle_ack/val  asynchronous NoC acknowledge / idle-granted qualifier
//   o_noc_clken               NoC clock enable
//
// Parameters: SYNC_STAGES >= 2, CLKEN_DLY >= 1, TIMEOUT_W = timer width.
module l2_noc_iso_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CLKEN_DLY   = 4,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_isolate_req,
    input  logic [TIMEOUT_W-1:0] i_timeout_cycles,
    output logic                 o_isolate_ack,
    output logic                 o_refused,
    output logic                 o_timeout,
    output logic [2:0]           o_state,
    output logic                 o_noc_async_idle_req,
    input  logic                 i_noc_async_idle_ack,
    input  logic                 i_noc_async_idle_val,
    output logic                 o_noc_clken
);

    localparam int unsigned DLY_W = (CLKEN_DLY > 1) ? $clog2(CLKEN_DLY) : 1;
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(CLKEN_DLY - 1);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_REQ      = 3'd1,
        ST_CLKOFF   = 3'd2,
        ST_ISOLATED = 3'd3,
        ST_WAKE     = 3'd4,
        ST_REL      = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [TIMEOUT_W-1:0] timer, timer_n, timer_inc;
    logic [DLY_W-1:0]     dly, dly_n, dly_inc;
    logic                 refused_n, timeout_n;
    logic                 idle_req_n, clken_n, iso_ack_n;

    logic [SYNC_STAGES-1:0] ack_sync, val_sync;
    logic                   ack_s, val_s;

    // NoC handshake synchronisers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_sync <= '0;
            val_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], i_noc_async_idle_ack};
            val_sync <= {val_sync[SYNC_STAGES-2:0], i_noc_async_idle_val};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign val_s = val_sync[SYNC_STAGES-1];

    // Saturating REQ timer and the shared CLKOFF/WAKE delay counter increments
    assign timer_inc = (timer == '1) ? timer : TIMEOUT_W'(timer + TIMEOUT_W'(1));
    assign dly_inc   = DLY_W'(dly + DLY_W'(1));

    // Next-state, counter and output decode
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        dly_n     = dly;
        refused_n = 1'b0;
        timeout_n = 1'b0;

        case (state)
            ST_RUN: begin
                timer_n = '0;
                if (i_isolate_req && !ack_s) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                timer_n = timer_inc;
                dly_n   = '0;
                if (ack_s && val_s) begin
                    state_n = ST_CLKOFF;
                end else if (ack_s) begin
                    refused_n = 1'b1;
                    state_n   = ST_REL;
                end else if (!i_isolate_req) begin
                    state_n = ST_REL;
                // timer_inc counts REQ cycles including this one, so the
                // pulse lands i_timeout_cycles cycles after REQ entry
                end else if ((i_timeout_cycles != '0) && (timer_inc == i_timeout_cycles)) begin
                    timeout_n = 1'b1;
                    state_n   = ST_REL;
                end
            end
            ST_CLKOFF: begin
                dly_n = dly_inc;
                if (dly == DLY_LAST) begin
                    dly_n   = '0;
                    state_n = ST_ISOLATED;
                end
            end
            ST_ISOLATED: begin
                dly_n = '0;
                if (!i_isolate_req) begin
                    state_n = ST_WAKE;
                end
            end
            ST_WAKE: begin
                dly_n = dly_inc;
                if (dly == DLY_LAST) begin
                    dly_n   = '0;
                    state_n = ST_REL;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_n = ST_RUN;
                end
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it
        idle_req_n = (state_n == ST_REQ) || (state_n == ST_CLKOFF) ||
                     (state_n == ST_ISOLATED) || (state_n == ST_WAKE);
        clken_n    = (state_n != ST_ISOLATED);
        iso_ack_n  = (state_n == ST_ISOLATED);
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                <= ST_RUN;
            timer                <= '0;
            dly                  <= '0;
            o_refused            <= 1'b0;
            o_timeout            <= 1'b0;
            o_noc_async_idle_req <= 1'b0;
            o_noc_clken          <= 1'b1;
            o_isolate_ack        <= 1'b0;
        end else begin
            state                <= state_n;
            timer                <= timer_n;
            dly                  <= dly_n;
            o_refused            <= refused_n;
            o_timeout            <= timeout_n;
            o_noc_async_idle_req <= idle_req_n;
            o_noc_clken          <= clken_n;
            o_isolate_ack        <= iso_ack_n;
        end
    end

    assign o_state = state;

endmodule

// File: doc/l2_noc_iso_ctrl.md
# l2_noc_iso_ctrl

NoC isolation controller for the L2 partition. It drives the partition's asynchronous NoC idle-request handshake and the NoC clock enable, in response to a level isolation request from the partition power/CSR logic. It sits directly on the `noc_async_idle_req/ack/val` and `noc_clken` lines between the L2 partition and the NoC fence. It synchronises the NoC-side handshake, gates the clock only after idle is confirmed, and reports refusal and timeout.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flop stages on `i_noc_async_idle_ack` and `i_noc_async_idle_val`; must be ≥ 2.
- `CLKEN_DLY`, default 4: cycles between idle confirmation and clken drop, and between clken rise and idle_req release; must be ≥ 1.
- `TIMEOUT_W`, default 16: width of the timeout counter and of `i_timeout_cycles`.

Ports:
- `i_clk`  in  1  fast clock, rising edge.
- `i_rst`  in  1  reset; **one clock; reset is asynchronous and active-high**.
- `i_isolate_req`  in  1  level request: 1 = isolate, 0 = run.
- `i_timeout_cycles`  in  TIMEOUT_W  REQ-state timeout in cycles; 0 disables the timeout.
- `o_isolate_ack`  out  1  1 while in ISOLATED.
- `o_refused`  out  1  one-cycle pulse when the NoC refuses the request.
- `o_timeout`  out  1  one-cycle pulse when the REQ timeout expires.
- `o_state`  out  3  current FSM state (debug).
- `o_noc_async_idle_req`  out  1  idle request to the NoC.
- `i_noc_async_idle_ack`  in  1  NoC acknowledge; asynchronous.
- `i_noc_async_idle_val`  in  1  NoC idle-granted qualifier; asynchronous.
- `o_noc_clken`  out  1  NoC clock enable.

## Operation
- **Synchronisers:** `ack_s` and `val_s` are SYNC_STAGES-flop synchronised copies, reset to 0. All FSM decisions use only `ack_s`/`val_s`.
- **State encoding:** RUN=0, REQ=1, CLKOFF=2, ISOLATED=3, WAKE=4, REL=5.
- **RUN:** idle_req=0, clken=1.
  - Go to REQ when `i_isolate_req`=1 and `ack_s`=0.
- **REQ:** idle_req=1. The timer clears on entry and increments each cycle, saturating at all-ones. Exits are evaluated in priority order:
  - (a) `ack_s`=1 and `val_s`=1 → CLKOFF.
  - (b) `ack_s`=1 and `val_s`=0 → pulse `o_refused`, go to REL.
  - (c) `i_isolate_req`=0 → REL (abort, no pulse).
  - (d) `i_timeout_cycles`≠0 and timer == `i_timeout_cycles` → pulse `o_timeout`, go to REL.
- **CLKOFF:** idle_req=1, clken=1. The delay counter clears on entry.
  - After CLKEN_DLY cycles in this state, go to ISOLATED.
  - `i_isolate_req` is ignored here.
- **ISOLATED:** idle_req=1, clken=0, `o_isolate_ack`=1.
  - Go to WAKE when `i_isolate_req`=0.
- **WAKE:** clken=1, idle_req=1.
  - After CLKEN_DLY cycles, go to REL.
- **REL:** idle_req=0, clken=1.
  - Go to RUN when `ack_s`=0.
  - If `i_isolate_req` is still 1, RUN re-enters REQ on the next cycle. This is the automatic retry after a refusal or timeout.
- All outputs are registered: state plus decoded flops. There are no combinational paths from inputs to outputs.

## Timing
- **Reset values:** state=RUN, `o_noc_async_idle_req`=0, `o_noc_clken`=1, `o_isolate_ack`=0, `o_refused`=0, `o_timeout`=0, `o_state`=0, all counters=0, synchronisers=0.
- **Reset mid-operation:** outputs return to reset values asynchronously. clken reasserts immediately even when reset is applied in ISOLATED.
- **Request to idle_req:** `i_isolate_req` rising in RUN → idle_req=1 on the next clock edge (1 cycle).
- **Ack latency:** a NoC ack/val change is visible to the FSM after SYNC_STAGES cycles. The exit state is registered one cycle later.
- **Grant to clken drop:** from `ack_s`&`val_s`=1 to `o_noc_clken`=0 is 1 + CLKEN_DLY cycles. `o_isolate_ack` rises in the same cycle clken falls.
- **Release sequence:** `i_isolate_req` falling in ISOLATED → clken=1 after 1 cycle. idle_req falls CLKEN_DLY cycles later.
- **Pulses:** `o_refused` and `o_timeout` are exactly one cycle wide and are never asserted together.
- **Simultaneous exits in REQ:** priority a > b > c > d, applied as listed above.
- **Timeout reprogramming:** changing `i_timeout_cycles` mid-REQ takes effect on the next comparison. A new value below the current timer never matches, so the controller waits until saturation; software must not do this.
- **Enable protocol:** clken is never 0 while idle_req=0. idle_req never falls while clken=0.

## Test plan
- **Nominal isolate/release** (SYNC_STAGES=2, CLKEN_DLY=4): raise req; NoC returns ack=val=1 two cycles after idle_req.
  - Expect clken=0 and `o_isolate_ack`=1 exactly 2+1+4 cycles after ack.
  - Drop req → clken=1 in 1 cycle, idle_req=0 4 cycles later.
  - NoC drops ack → `o_state`=RUN after 3 cycles.
- **Refusal and retry:** NoC returns ack=1, val=0.
  - Expect one `o_refused` pulse, idle_req low until `ack_s`=0, then automatic re-request.
  - Second attempt granted → ISOLATED.
- **Timeout:** `i_timeout_cycles`=10, NoC never acks.
  - Expect `o_timeout` pulse 10 cycles after REQ entry, then idle_req=0 and retry.
  - With `i_timeout_cycles`=0, no pulse in 1000 cycles.
- **Abort:** drop req 3 cycles into REQ with no ack.
  - Expect REL → RUN, no pulses, clken stays 1 throughout.
- **Reset in ISOLATED:** assert `i_rst` asynchronously.
  - Expect clken=1, idle_req=0, ack=0 before the next clock edge; state=RUN.
- **Simultaneous grant and req drop in REQ:** grant wins.
  - Expect CLKOFF → ISOLATED → WAKE immediately, with idle_req high until WAKE completes.
